team_04_wb_master: RTL and testbench

Wishbone classic (B4, non-pipelined) master that turns single-word read/write commands from user logic into bus cycles on the team's master port (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I) toward the Nebula Wishbone arbitrator. It is the initiator counterpart of the team's slave bus wrapper. It replaces the tied-off master outputs in the team wrapper. It also adds an ACK timeout so a non-responding target cannot hang user logic.

---
 rtl/team_04_wb_master_pkg.sv | 15 +
 rtl/team_04_wb_master_if.sv | 25 ++
 rtl/team_04_wb_timer.sv | 35 +++
 rtl/team_04_wb_master.sv | 130 +++++++++++++
 tb/tb_team_04_wb_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/team_04_wb_master_pkg.sv
// Shared definitions for the Wishbone classic master: FSM state encoding,
// bus word/select widths and the default ACK timeout.
package team_04_wb_master_pkg;

  localparam int WB_WORD_W       = 32;
  localparam int WB_SEL_W        = 4;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/team_04_wb_master_if.sv
// Wishbone classic (B4) master-side bus bundle.
// master modport: drives ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, samples DAT_I/ACK_I.
// slave modport : the mirror image, for a target model or the arbitrator side.
interface team_04_wb_master_if;
  import team_04_wb_master_pkg::*;

  logic [WB_WORD_W-1:0] ADR_O;
  logic [WB_WORD_W-1:0] DAT_O;
  logic [WB_SEL_W-1:0]  SEL_O;
  logic                 WE_O;
  logic                 STB_O;
  logic                 CYC_O;
  logic [WB_WORD_W-1:0] DAT_I;
  logic                 ACK_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/team_04_wb_timer.sv
// ACK timeout counter for the Wishbone master.
// Ports: clk_i/nrst clock and async active-low reset; clr forces the count
// to 0; en advances it by one (saturating, never wraps); expired is high
// while the count equals TIMEOUT_CYC-1, i.e. during the last allowed cycle.
module team_04_wb_timer
  import team_04_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/team_04_wb_master.sv
// Wishbone classic (B4, non-pipelined) single-word master with ACK timeout.
// Ports:
//   clk_i, nrst           clock, async active-low reset
//   req_*                 command in (valid/ready), we/adr/dat/sel
//   rsp_*                 response out (valid/ready), read data, timeout error
//   busy_o                high whenever the FSM is not IDLE
//   wb (master modport)   ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I
// All bus outputs come straight from flops; ACK_I only reaches flop inputs.
module team_04_wb_master
  import team_04_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk_i,
  input  logic                 nrst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [WB_WORD_W-1:0] req_adr_i,
  input  logic [WB_WORD_W-1:0] req_dat_i,
  input  logic [WB_SEL_W-1:0]  req_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_WORD_W-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  team_04_wb_master_if.master  wb
);

  // Word-align the byte address when the command is registered.
  localparam logic [WB_WORD_W-1:0] ADR_MASK = ~WB_WORD_W'(3);

  state_t               state_q, state_d;
  logic                 load_cmd;
  logic                 leave_bus;
  logic                 expired;

  logic [WB_WORD_W-1:0] adr_q;
  logic [WB_WORD_W-1:0] dat_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic                 we_q;
  logic                 cyc_q;
  logic [WB_WORD_W-1:0] rsp_dat_q;
  logic                 rsp_err_q;

  team_04_wb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i   (clk_i),
    .nrst    (nrst),
    .clr     (state_q != BUS),
    .en      ((state_q == BUS) && !wb.ACK_I),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ACK takes priority over the final timeout cycle.
  always_comb begin
    state_d   = state_q;
    load_cmd  = 1'b0;
    leave_bus = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          load_cmd = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        if (wb.ACK_I || expired) begin
          leave_bus = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (load_cmd) begin
      adr_q <= req_adr_i & ADR_MASK;
      dat_q <= req_we_i ? req_dat_i : '0;
      sel_q <= req_sel_i;
      we_q  <= req_we_i;
      cyc_q <= 1'b1;
    end else if (leave_bus) begin
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      rsp_dat_q <= (wb.ACK_I && !we_q) ? wb.DAT_I : '0;
      rsp_err_q <= !wb.ACK_I;
    end
  end

  assign wb.ADR_O = adr_q;
  assign wb.DAT_O = dat_q;
  assign wb.SEL_O = sel_q;
  assign wb.WE_O  = we_q;
  assign wb.STB_O = cyc_q;
  assign wb.CYC_O = cyc_q;

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_team_04_wb_master.sv
// Directed bench for team_04_wb_master (TIMEOUT_CYC=8); the bench plays the
// Wishbone slave by driving ACK_I/DAT_I step by step.
module tb_team_04_wb_master;

  logic        clk_i = 1'b0;
  logic        nrst  = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int stb_cnt;

  team_04_wb_master_if wb ();

  team_04_wb_master #(.TIMEOUT_CYC(8)) dut (
    .clk_i       (clk_i),
    .nrst        (nrst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .wb          (wb.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, "_rvld"},  {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({tag, "_bus"},   {26'd0, wb.STB_O, wb.CYC_O, wb.WE_O, wb.SEL_O != 4'd0, wb.ADR_O != 32'd0, wb.DAT_O != 32'd0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.ACK_I = 1'b0;
    wb.DAT_I = '0;
    tick();
    tick();
    // reset state
    idle_outs("reset");
    chk("reset_rdat", rsp_dat_o, 32'd0);
    chk("reset_err", {31'd0, rsp_err_o}, 32'd0);
    nrst = 1'b1;
    tick();

    // zero-wait write
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h3000_0004;
    req_dat_i = 32'hA5A5_1234; req_sel_i = 4'hF;
    tick();
    req_valid_i = 1'b0;
    chk("wr_stb", {30'd0, wb.STB_O, wb.CYC_O}, 32'd3);
    chk("wr_we", {31'd0, wb.WE_O}, 32'd1);
    chk("wr_dat", wb.DAT_O, 32'hA5A5_1234);
    chk("wr_adr", wb.ADR_O, 32'h3000_0004);
    chk("wr_sel", {28'd0, wb.SEL_O}, 32'hF);
    chk("wr_ready", {31'd0, req_ready_o}, 32'd0);
    chk("wr_rvld0", {31'd0, rsp_valid_o}, 32'd0);
    wb.ACK_I = 1'b1;
    tick();
    wb.ACK_I = 1'b0;
    chk("wr_stb_off", {30'd0, wb.STB_O, wb.CYC_O}, 32'd0);
    chk("wr_rvld", {31'd0, rsp_valid_o}, 32'd1);
    chk("wr_err", {31'd0, rsp_err_o}, 32'd0);
    chk("wr_rdat", rsp_dat_o, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    idle_outs("wr_done");

    // 3-wait read, then response backpressure and spurious ACK in RESP
    req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h3000_0013;
    req_dat_i = 32'hFFFF_FFFF; req_sel_i = 4'h3;
    tick();
    req_valid_i = 1'b0;
    chk("rd_adr", wb.ADR_O, 32'h3000_0010);
    chk("rd_we", {31'd0, wb.WE_O}, 32'd0);
    chk("rd_dat_o", wb.DAT_O, 32'd0);
    chk("rd_sel", {28'd0, wb.SEL_O}, 32'h3);
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_stb", {31'd0, wb.STB_O}, 32'd1);
      chk("rd_wait_rvld", {31'd0, rsp_valid_o}, 32'd0);
      tick();
    end
    wb.ACK_I = 1'b1; wb.DAT_I = 32'hDEAD_BEEF;
    tick();
    wb.ACK_I = 1'b0; wb.DAT_I = 32'h0;
    chk("rd_bus_rel", {30'd0, wb.STB_O, wb.CYC_O}, 32'd0);
    chk("rd_rvld", {31'd0, rsp_valid_o}, 32'd1);
    chk("rd_rdat", rsp_dat_o, 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, rsp_err_o}, 32'd0);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h0000_0040;
    req_dat_i = 32'h0000_0011; req_sel_i = 4'h1;
    for (int i = 0; i < 5; i++) begin
      wb.ACK_I = (i >= 2); wb.DAT_I = 32'h1234_5678;
      tick();
      chk("bp_rvld", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp_rdat", rsp_dat_o, 32'hDEAD_BEEF);
      chk("bp_err", {31'd0, rsp_err_o}, 32'd0);
      chk("bp_ready", {31'd0, req_ready_o}, 32'd0);
      chk("bp_stb", {31'd0, wb.STB_O}, 32'd0);
    end
    wb.ACK_I = 1'b0; wb.DAT_I = 32'h0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("bp_idle_ready", {31'd0, req_ready_o}, 32'd1);
    chk("bp_idle_stb", {31'd0, wb.STB_O}, 32'd0);
    tick();
    req_valid_i = 1'b0;
    chk("bp_new_stb", {31'd0, wb.STB_O}, 32'd1);
    chk("bp_new_adr", wb.ADR_O, 32'h0000_0040);
    chk("bp_new_dat", wb.DAT_O, 32'h0000_0011);
    wb.ACK_I = 1'b1;
    tick();
    wb.ACK_I = 1'b0;
    chk("bp_new_rvld", {31'd0, rsp_valid_o}, 32'd1);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // timeout with no ACK: exactly 8 STB cycles
    req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0100; req_sel_i = 4'hF;
    wb.DAT_I = 32'hAAAA_5555;
    tick();
    req_valid_i = 1'b0;
    stb_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (rsp_valid_o) break;
      if (wb.STB_O) stb_cnt++;
      tick();
    end
    chk("to_stb_cycles", stb_cnt, 32'd8);
    chk("to_rvld", {31'd0, rsp_valid_o}, 32'd1);
    chk("to_err", {31'd0, rsp_err_o}, 32'd1);
    chk("to_rdat", rsp_dat_o, 32'd0);
    chk("to_stb_off", {31'd0, wb.STB_O}, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // ACK on the final (8th) STB cycle wins over timeout
    req_valid_i = 1'b1;
    wb.DAT_I = 32'h0BAD_F00D;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("ack8_stb", {31'd0, wb.STB_O}, 32'd1);
    chk("ack8_rvld0", {31'd0, rsp_valid_o}, 32'd0);
    wb.ACK_I = 1'b1;
    tick();
    wb.ACK_I = 1'b0; wb.DAT_I = 32'h0;
    chk("ack8_rvld", {31'd0, rsp_valid_o}, 32'd1);
    chk("ack8_err", {31'd0, rsp_err_o}, 32'd0);
    chk("ack8_rdat", rsp_dat_o, 32'h0BAD_F00D);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // spurious ACK in IDLE
    wb.ACK_I = 1'b1; wb.DAT_I = 32'hFFFF_0000;
    tick();
    tick();
    wb.ACK_I = 1'b0; wb.DAT_I = 32'h0;
    idle_outs("spur_idle");
    chk("spur_idle_rdat", rsp_dat_o, 32'h0BAD_F00D);
    tick();
    idle_outs("spur_idle2");

    // reset mid-BUS during wait states
    req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h0000_0200;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("rst_pre_stb", {31'd0, wb.STB_O}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("rst_async_bus", {30'd0, wb.STB_O, wb.CYC_O}, 32'd0);
    chk("rst_async_rdat", rsp_dat_o, 32'd0);
    tick();
    nrst = 1'b1;
    idle_outs("rst_rel");
    tick();
    tick();
    idle_outs("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
